// File: rtl/rtlmem_fifo_ctrl.sv
// rtlmem_fifo_ctrl
//   Synchronous FIFO controller for a 1R/1W memory with a 1-cycle read latency.
//   It owns the write and read pointers and reads ahead into a 2-entry output
//   buffer. The pop side is first-word-fall-through with valid/ready. After
//   reset, and optionally on flush, it runs the memory clear handshake.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   flush               synchronous flush pulse, accepted in any state
//   busy                high while the clear sequence runs (same as clren)
//   push_vld/dat/rdy    producer side
//   pop_vld/dat/rdy     consumer side; pop_dat is the registered buffer head
//   count               entries held: in memory + read in flight + buffered
//   memwe/memwa/memdi   memory write port
//   memre/memra/memdo   memory read port; memdo is valid 1 cycle after memre
//   clren/clrrdy        memory clear request / clear complete
module rtlmem_fifo_ctrl #(
  parameter int G_ADDR         = 10,
  parameter int G_WIDTH        = 16,
  parameter int G_DEPTH        = 2**G_ADDR,
  parameter int G_CLR_ON_FLUSH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  output logic               busy,
  input  logic               push_vld,
  input  logic [G_WIDTH-1:0] push_dat,
  output logic               push_rdy,
  output logic               pop_vld,
  output logic [G_WIDTH-1:0] pop_dat,
  input  logic               pop_rdy,
  output logic [G_ADDR:0]    count,
  output logic               memwe,
  output logic [G_ADDR-1:0]  memwa,
  output logic [G_WIDTH-1:0] memdi,
  output logic               memre,
  output logic [G_ADDR-1:0]  memra,
  input  logic [G_WIDTH-1:0] memdo,
  output logic               clren,
  input  logic               clrrdy
);

  localparam logic [G_ADDR:0]   DEPTH_C  = (G_ADDR+1)'(G_DEPTH);
  localparam logic [G_ADDR-1:0] LAST_PTR = G_ADDR'(G_DEPTH-1);

  typedef enum logic {CLR, RUN} state_t;

  state_t              state_reg, state_next;
  // dwell_reg holds the 1-based index of the current CLR cycle, saturating at 3.
  // The exit test "dwell >= 2" therefore allows RUN after 2 CLR cycles at the
  // earliest. A clrrdy that was left over from before entry cannot end the
  // sequence in its first cycle.
  logic [1:0]          dwell_reg, dwell_next;
  logic [G_ADDR-1:0]   wptr_reg, rptr_reg;
  logic [G_ADDR:0]     memcnt_reg;
  logic                infl_reg;
  logic [1:0]          bufcnt_reg;
  logic [G_WIDTH-1:0]  buf_reg [2];

  logic                run;
  logic                push_fire;
  logic                pop_fire;
  logic [2:0]          pend;
  logic                cap_to_head;

  function automatic logic [G_ADDR-1:0] ptr_inc(input logic [G_ADDR-1:0] p);
    return (p == LAST_PTR) ? '0 : p + G_ADDR'(1);
  endfunction

  assign run       = (state_reg == RUN);
  assign clren     = (state_reg == CLR);
  assign busy      = clren;
  assign count     = memcnt_reg + (G_ADDR+1)'(infl_reg) + (G_ADDR+1)'(bufcnt_reg);
  assign push_rdy  = run && (count < DEPTH_C);
  assign pop_vld   = (bufcnt_reg != 2'd0);
  assign pop_dat   = buf_reg[0];
  assign pop_fire  = pop_vld && pop_rdy;
  assign push_fire = push_vld && push_rdy && !flush;

  // Issue a read only when the word has room to land. Room means the buffer
  // plus the in-flight word, less this cycle's pop, stays below 2. Because of
  // the pop term, pop_rdy reaches memre through combinational logic.
  assign pend  = {1'b0, bufcnt_reg} + {2'b00, infl_reg} - {2'b00, pop_fire};
  assign memre = run && !flush && (memcnt_reg != '0) && (pend < 3'd2);

  assign memwe = push_fire;
  assign memwa = wptr_reg;
  assign memdi = push_fire ? push_dat : '0;
  assign memra = rptr_reg;

  // The returning word goes to the first free slot after this cycle's pop.
  assign cap_to_head = ((bufcnt_reg - 2'(pop_fire)) == 2'd0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLR;
      dwell_reg <= 2'd1;
    end else begin
      state_reg <= state_next;
      dwell_reg <= dwell_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dwell_next = dwell_reg;
    if (flush) begin
      state_next = (G_CLR_ON_FLUSH != 0) ? CLR : RUN;
      dwell_next = 2'd1;
    end else begin
      case (state_reg)
        CLR: begin
          if (clrrdy && (dwell_reg >= 2'd2)) begin
            state_next = RUN;
            dwell_next = 2'd1;
          end else if (dwell_reg != 2'd3) begin
            dwell_next = dwell_reg + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg   <= '0;
      rptr_reg   <= '0;
      memcnt_reg <= '0;
      infl_reg   <= 1'b0;
      bufcnt_reg <= 2'd0;
    end else if (flush) begin
      // Clearing infl_reg drops any word still returning on memdo.
      wptr_reg   <= '0;
      rptr_reg   <= '0;
      memcnt_reg <= '0;
      infl_reg   <= 1'b0;
      bufcnt_reg <= 2'd0;
    end else begin
      if (push_fire) wptr_reg <= ptr_inc(wptr_reg);
      if (memre)     rptr_reg <= ptr_inc(rptr_reg);
      memcnt_reg <= memcnt_reg + (G_ADDR+1)'(push_fire) - (G_ADDR+1)'(memre);
      infl_reg   <= memre;
      bufcnt_reg <= bufcnt_reg - 2'(pop_fire) + 2'(infl_reg);
    end
  end

  // ---------------------------------------------------------------- output buffer (head in slot 0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_reg[0] <= '0;
      buf_reg[1] <= '0;
    end else if (!flush) begin
      if (pop_fire) buf_reg[0] <= buf_reg[1];
      if (infl_reg) begin
        if (cap_to_head) buf_reg[0] <= memdo;
        else             buf_reg[1] <= memdo;
      end
    end
  end

endmodule

// File: tb/tb_rtlmem_fifo_ctrl.sv
// tb_rtlmem_fifo_ctrl
//   Drives rtlmem_fifo_ctrl (G_ADDR=3, G_DEPTH=6) with directed and random
//   traffic. A behavioural 1R/1W memory supplies the read data. A queue model
//   holds the expected FIFO contents, and modulo-depth counters give the
//   expected memory addresses.
module tb_rtlmem_fifo_ctrl;

  localparam int A = 3;
  localparam int W = 16;
  localparam int D = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         busy;
  logic         push_vld = 1'b0;
  logic [W-1:0] push_dat = '0;
  logic         push_rdy;
  logic         pop_vld;
  logic [W-1:0] pop_dat;
  logic         pop_rdy = 1'b0;
  logic [A:0]   count;
  logic         memwe;
  logic [A-1:0] memwa;
  logic [W-1:0] memdi;
  logic         memre;
  logic [A-1:0] memra;
  logic [W-1:0] memdo = '0;
  logic         clren;
  logic         clrrdy = 1'b0;

  rtlmem_fifo_ctrl #(
    .G_ADDR(A), .G_WIDTH(W), .G_DEPTH(D), .G_CLR_ON_FLUSH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy),
    .push_vld(push_vld), .push_dat(push_dat), .push_rdy(push_rdy),
    .pop_vld(pop_vld), .pop_dat(pop_dat), .pop_rdy(pop_rdy),
    .count(count),
    .memwe(memwe), .memwa(memwa), .memdi(memdi),
    .memre(memre), .memra(memra), .memdo(memdo),
    .clren(clren), .clrrdy(clrrdy)
  );

  always #5 clk = ~clk;

  // Behavioural memory with a 1-cycle read latency.
  logic [W-1:0] mem [2**A];
  always @(posedge clk) begin
    if (memwe) mem[memwa] <= memdi;
    if (memre) memdo <= mem[memra];
  end

  int n_chk = 0;
  int n_bad = 0;
  logic [W-1:0] q[$];
  int wp = 0;
  int rp = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Call at a negedge. It checks the outputs against the model, applies the
  // inputs for the next edge, updates the model, and returns at the next negedge.
  task automatic cyc(input bit pv, input logic [W-1:0] pd, input bit pr, input bit fl);
    bit pushf, popf;
    check("count", 32'(count), 32'(q.size()));
    check("push_rdy", 32'(push_rdy), 32'(!busy && (q.size() < D)));
    if (q.size() == 0) check("pop_vld_empty", 32'(pop_vld), 32'(0));
    else if (pop_vld)  check("pop_dat", 32'(pop_dat), 32'(q[0]));
    push_vld = pv; push_dat = pd; pop_rdy = pr; flush = fl;
    #1;
    pushf = pv && push_rdy && !fl;
    popf  = pop_vld && pr && !fl;
    check("memwe", 32'(memwe), 32'(pushf));
    if (pushf) begin
      check("memwa", 32'(memwa), 32'(wp));
      check("memdi", 32'(memdi), 32'(pd));
    end
    if (fl) check("memre_flush", 32'(memre), 32'(0));
    if (memre) begin
      check("memra", 32'(memra), 32'(rp));
      rp = (rp + 1) % D;
    end
    if (fl) begin
      q.delete(); wp = 0; rp = 0;
    end else begin
      if (popf) void'(q.pop_front());
      if (pushf) begin q.push_back(pd); wp = (wp + 1) % D; end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset(input bit cr);
    clrrdy = cr; flush = 0; push_vld = 0; pop_rdy = 0; push_dat = '0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("rst_pop_vld", 32'(pop_vld), 32'(0));
    check("rst_pop_dat", 32'(pop_dat), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    check("rst_push_rdy", 32'(push_rdy), 32'(0));
    check("rst_memwe", 32'(memwe), 32'(0));
    check("rst_memre", 32'(memre), 32'(0));
    check("rst_memwa", 32'(memwa), 32'(0));
    check("rst_memra", 32'(memra), 32'(0));
    check("rst_memdi", 32'(memdi), 32'(0));
    check("rst_clren", 32'(clren), 32'(1));
    check("rst_busy", 32'(busy), 32'(1));
    rst_n = 1;
    q.delete(); wp = 0; rp = 0;
  endtask

  task automatic drain(input string tag, input bit rnd);
    for (int k = 0; k < 200 && q.size() != 0; k++) cyc(0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 0);
    check(tag, 32'(q.size()), 32'(0));
  endtask

  logic [W-1:0] held;

  initial begin
    // Stale-clear case: clrrdy low keeps the controller in CLR.
    apply_reset(0);
    for (int k = 0; k < 50; k++) @(negedge clk);
    check("clr_hold_busy", 32'(busy), 32'(1));
    check("clr_hold_rdy", 32'(push_rdy), 32'(0));
    clrrdy = 1;
    for (int k = 0; k < 10 && busy; k++) @(negedge clk);
    check("clr_exit", 32'(busy), 32'(0));

    // clrrdy tied high: clren is high for exactly 2 cycles.
    apply_reset(1);
    check("clren_c0", 32'(clren), 32'(1));
    @(negedge clk);
    check("clren_c1", 32'(clren), 32'(1));
    @(negedge clk);
    check("clren_c2", 32'(clren), 32'(0));
    check("busy_c2", 32'(busy), 32'(0));
    check("push_rdy_c2", 32'(push_rdy), 32'(1));

    // Latency of a single word through an empty FIFO.
    cyc(1, 16'hA5A5, 1, 0);
    push_vld = 0; #1;
    check("lat_memre_c1", 32'(memre), 32'(1));
    check("lat_memra_c1", 32'(memra), 32'(0));
    cyc(0, '0, 1, 0);
    check("lat_memre_c2", 32'(memre), 32'(0));
    check("lat_pop_vld_c2", 32'(pop_vld), 32'(0));
    cyc(0, '0, 1, 0);
    check("lat_pop_vld_c3", 32'(pop_vld), 32'(1));
    check("lat_pop_dat_c3", 32'(pop_dat), 32'(16'hA5A5));
    cyc(0, '0, 1, 0);
    check("lat_count_end", 32'(count), 32'(0));
    check("lat_pop_vld_end", 32'(pop_vld), 32'(0));

    // Fill to depth, then two passes that wrap the pointers.
    for (int i = 0; i < D; i++) cyc(1, 16'(i), 0, 0);
    check("full_rdy", 32'(push_rdy), 32'(0));
    check("full_count", 32'(count), 32'(D));
    cyc(1, 16'h0099, 0, 0);
    drain("drain_pass1", 1);
    for (int i = 0; i < D; i++) cyc(1, 16'(D + i), 1'($urandom_range(0, 1)), 0);
    drain("drain_pass2", 1);

    // Streaming: one push and one pop every cycle.
    for (int i = 0; i < 1000; i++) begin
      if (i >= 3) begin
        check("stream_pop_vld", 32'(pop_vld), 32'(1));
        check("stream_count", 32'(count), 32'(3));
      end
      cyc(1, 16'(16'h0100 + i), 1, 0);
    end
    drain("drain_stream", 0);

    // Back-pressure: 4 entries are held and the consumer stalls for 20 cycles.
    for (int i = 0; i < 4; i++) cyc(1, 16'(16'h0200 + i), 0, 0);
    held = 16'h0200;
    for (int k = 0; k < 20; k++) begin
      check("stall_memre", 32'(memre), 32'(0));
      check("stall_pop_dat", 32'(pop_dat), 32'(held));
      check("stall_count", 32'(count), 32'(4));
      cyc(0, '0, 0, 0);
    end
    drain("drain_stall", 0);

    // Flush while a read is returning, with 3 entries held.
    cyc(1, 16'h0301, 0, 0);
    cyc(1, 16'h0302, 0, 0);
    cyc(1, 16'h0303, 0, 0);
    check("flush_pre_count", 32'(count), 32'(3));
    cyc(0, '0, 0, 1);
    check("flush_count", 32'(count), 32'(0));
    check("flush_pop_vld", 32'(pop_vld), 32'(0));
    check("flush_busy", 32'(busy), 32'(1));
    for (int k = 0; k < 4; k++) cyc(0, '0, 1, 0);
    check("flush_run", 32'(busy), 32'(0));
    cyc(1, 16'h1234, 1, 0);
    drain("drain_flush", 0);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 1500; k++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 79) == 0));
    drain("drain_random", 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/rtlmem_fifo_ctrl.md
# rtlmem_fifo_ctrl

Synchronous FIFO controller that drives a 1-read/1-write, 1-cycle-read-latency memory wrapper (`rtlmem_1r1w1x` class) from the initiator side. It owns the write/read pointers, issues memory reads ahead of demand into a 2-entry output buffer, and presents a first-word-fall-through valid/ready pop port. It also sequences the memory's clear handshake after reset and on flush. It sits between a producer/consumer pair and one memory instance on a single clock.

## Interface
- G_ADDR, 10, memory address width
- G_WIDTH, 16, data width
- G_DEPTH, 2**G_ADDR, memory entries; any value 2..2**G_ADDR
- G_CLR_ON_FLUSH, 1, 1: flush runs the memory clear sequence; 0: flush only resets pointers

Ports:
- clk  in  1  single clock; memory wclk and rclk are both tied to it
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush request, single-cycle pulse
- busy  out  1  high while in CLR state
- push_vld  in  1  producer data valid
- push_dat  in  G_WIDTH  producer data
- push_rdy  out  1  controller can accept
- pop_vld  out  1  pop_dat valid
- pop_dat  out  G_WIDTH  head-of-FIFO data, registered
- pop_rdy  in  1  consumer accepts
- count  out  G_ADDR+1  total entries held (memory + in-flight + buffer)
- memwe, memwa[G_ADDR], memdi[G_WIDTH]  out  memory write port
- memre, memra[G_ADDR]  out  memory read port
- memdo  in  G_WIDTH  memory read data, valid 1 cycle after memre
- clren  out  1  memory clear request
- clrrdy  in  1  memory clear complete

## Operation
- States: CLR, RUN. Reset enters CLR. clren = (state==CLR); busy = clren.
- CLR: push_rdy=0, memwe=0, memre=0. Dwell counter (2 bits) counts CLR cycles; CLR->RUN at the edge where clrrdy==1 and dwell>=2. This minimum dwell rejects a stale clrrdy.
- Push: push_rdy = RUN & (count < G_DEPTH). On push_vld&push_rdy: memwe=1, memwa=wptr, memdi=push_dat. wptr advances, wrapping G_DEPTH-1 -> 0. memcnt increments.
- Read issue: memre = RUN & (memcnt!=0) & (bufcnt + infl - pop_fire < 2). pop_fire = pop_vld & pop_rdy. The pop_rdy->memre combinational path is intended. On memre: memra=rptr, rptr advances with wrap, memcnt decrements, infl=1 next cycle.
- Capture: when infl==1, memdo is written into the output buffer (2-entry circular or shift). pop_vld = (bufcnt!=0). pop_dat = buffer head.
- Only entries written in earlier cycles are read; memcnt updates at the write edge. Same-address read/write in one cycle therefore never occurs on live data.
- count = memcnt + infl + bufcnt. Simultaneous push and pop leave count unchanged.
- flush (accepted in any state) overrides push/pop in its cycle:
  - zeroes wptr, rptr, memcnt, infl, bufcnt;
  - drops any memdo returning next cycle;
  - enters CLR if G_CLR_ON_FLUSH=1 (dwell restarts), otherwise stays/enters RUN.
  - memwe=0 and memre=0 in the flush cycle.
- flush during CLR restarts the dwell counter.

## Timing
- Reset values: pop_vld=0, pop_dat=0, count=0, push_rdy=0, memwe=0, memre=0, memwa=0, memra=0, memdi=0, clren=1, busy=1.
- Push-to-pop latency on an empty FIFO:
  - push fire in cycle 0;
  - memre in cycle 1;
  - memdo valid in cycle 2;
  - pop_vld=1 in cycle 3.
- Sustained throughput is 1 push and 1 pop per cycle once the buffer is primed.
- pop_dat is held stable while pop_vld & !pop_rdy.
- push_rdy deasserts in the cycle after count reaches G_DEPTH. It reasserts the cycle after any pop_fire.
- Exit from CLR: push_rdy can rise at the earliest 2 cycles after CLR entry.

## Test plan
- Reset release with clrrdy tied 1 -> clren high exactly 2 cycles, then busy=0 and push_rdy=1. With clrrdy held 0 for 50 cycles -> stays in CLR 50+ cycles.
- Single push 0xA5A5 into empty FIFO, pop_rdy=1 -> memre in cycle 1 with memra=0, pop_vld in cycle 3 with pop_dat=0xA5A5, count returns to 0.
- G_ADDR=3, G_DEPTH=6: push 0..5 -> push_rdy=0 at count=6. Then pop all with random pop_rdy -> data 0..5 in order, pointers wrap 5->0 on a second pass of 6 items.
- Continuous push and pop every cycle for 1000 words -> no bubble after priming, count stays at 3, data in order.
- pop_rdy=0 for 20 cycles with 4 entries stored -> bufcnt=2, memre=0, pop_dat held stable, count=4.
- flush in the cycle where memdo returns with 3 entries held -> count=0, pop_vld=0 next cycle, returned word never appears. G_CLR_ON_FLUSH=1 re-enters CLR; G_CLR_ON_FLUSH=0 accepts a push the next cycle.
